instr_fetch_stream: RTL
=======================

Name: instr_fetch_stream

Overview:
- Parametrised instruction fetch unit: a streamed byte loader fills an internal instruction memory, then a PC-driven fetch engine issues instructions over a valid/ready handshake.
- Sits between the boot/loader path and the decode stage.
- Adds over the previous fetch block: runtime byte-stream loading instead of file preload, configurable width/depth/endianness, downstream back-pressure, branch flush, reload, and an out-of-range/misalignment fault.

Parameters:
- INSTR_W, 32, instruction width in bits; must be a multiple of 8.
- DEPTH, 64, instruction memory depth in words.
- ADDR_W, 32, byte-address width of PC and branch target.
- PC_INCR, 4, sequential PC increment in bytes; must equal INSTR_W/8.
- BIG_ENDIAN, 1, byte order: 1 = first streamed byte is the MSB; 0 = first streamed byte is the LSB.

Ports:
- clk  in  1  global clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ld_valid  in  1  loader byte valid.
- ld_ready  out  1  loader byte accepted when ld_valid && ld_ready.
- ld_byte  in  8  loader data byte.
- ld_last  in  1  marks final byte of the image; sampled with the byte.
- reload  in  1  in FETCH: abandon fetch and re-enter LOAD.
- branch  in  1  redirect PC to branch_target.
- branch_target  in  ADDR_W  byte address of the redirect.
- out_valid  out  1  instruction/pc_out valid.
- out_ready  in  1  downstream accepts on out_valid && out_ready.
- instruction  out  INSTR_W  fetched instruction.
- pc_out  out  ADDR_W  byte address of instruction.
- loading  out  1  high while in LOAD.
- fault  out  1  sticky fault flag.

Behaviour:
- Clock and reset: clk, rising edge; rst is asynchronous and active-high.
- Reset values: state = LOAD; ld_ready = 1; loading = 1; out_valid = 0; instruction = 0; pc_out = 0; fault = 0; pc = 0; word_idx = 0; byte_cnt = 0. Memory contents are not cleared. A reset asserted mid-operation aborts any partial word and any in-flight output.
- States: LOAD, FETCH, FAULT.
- LOAD:
  - Each accepted byte goes into the packer at lane byte_cnt, ordered per BIG_ENDIAN; byte_cnt increments.
  - When byte_cnt reaches INSTR_W/8 - 1 on an accept, the assembled word is written to mem[word_idx]; word_idx++ and byte_cnt returns to 0.
  - ld_last on an accept: a partial word is zero-padded in its unfilled lanes and written. The transition to FETCH happens the next cycle, and ld_ready = 0 from that cycle.
  - If word_idx reaches DEPTH after a write, the block goes to FETCH and further bytes are refused (ld_ready = 0). This happens with or without ld_last.
  - On entering FETCH: pc = 0 and loading = 0.
- FETCH:
  - issue = !branch && !reload && (!out_valid || out_ready).
  - On issue with pc aligned and pc/PC_INCR < DEPTH:
    - next cycle: instruction = mem[pc/PC_INCR], pc_out = pc, out_valid = 1.
    - pc += PC_INCR, wrapping modulo 2^ADDR_W.
    - Latency is one cycle; throughput is one instruction per cycle under a continuously ready downstream.
  - On issue with pc out of range: go to FAULT.
  - No issue and out_valid && out_ready: out_valid = 0.
  - While out_valid && !out_ready: instruction and pc_out hold stable.
- branch (priority over issue):
  - out_valid = 0 next cycle, so a held instruction is flushed.
  - pc = branch_target.
  - A target misaligned to PC_INCR goes to FAULT.
- reload (priority over branch): out_valid = 0; word_idx = 0; byte_cnt = 0; state = LOAD; ld_ready = 1.
- FAULT: fault = 1, out_valid = 0, ld_ready = 0. Only rst exits FAULT.
- LOAD ignores branch and reload.

Decomposition:
- Package instr_fetch_pkg: state encoding (LOAD/FETCH/FAULT), BYTES_PER_WORD = INSTR_W/8, IDX_W = clog2(DEPTH), CNT_W = clog2(BYTES_PER_WORD).
- Sub-module byte_packer: byte lane assembly with endianness and zero padding; emits word plus word_done.
- Memory: inline register array, synchronous write, registered read.

Test Plan:
- Stream 8 bytes 11..88, ld_last on 88, BIG_ENDIAN=1, out_ready=1 -> instructions 0x11223344 @pc 0, then 0x55667788 @pc 4, back-to-back; third issue (pc 8 < DEPTH) returns the old memory word.
- Same stream with BIG_ENDIAN=0 -> 0x44332211, 0x88776655.
- 5 bytes AA BB CC DD EE, last on EE -> word1 = 0xEE000000 (big endian); ld_ready low the cycle after EE.
- Hold out_ready=0 for 3 cycles with out_valid=1 -> instruction and pc_out stable, pc not advancing; release -> next pc+4 issued the following cycle.
- Branch to 0x8 while out_valid=1 && !out_ready -> out_valid=0 next cycle, then pc_out=8; branch to 0x6 -> fault=1 sticky until rst.
- DEPTH=4, stream 20 bytes without ld_last -> ld_ready drops after byte 16. Fetching pc 16 -> fault. Assert rst mid-stream -> ld_ready=1, out_valid=0, fault=0 asynchronously.

Source files
------------

// File: rtl/instr_fetch_stream_pkg.sv
// Shared state encoding and sizing helpers for the streamed instruction fetch unit.
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_t;

    localparam int DEF_INSTR_W    = 32;
    localparam int DEF_DEPTH      = 64;
    localparam int BYTES_PER_WORD = DEF_INSTR_W / 8;
    localparam int IDX_W          = $clog2(DEF_DEPTH);
    localparam int CNT_W          = $clog2(BYTES_PER_WORD);

    function automatic int bytes_per_word(input int instr_w);
        return instr_w / 8;
    endfunction

    // Counter/index widths never collapse to zero bits for degenerate sizes.
    function automatic int idx_bits(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/instr_fetch_stream_byte_packer.sv
// Assembles streamed bytes into instruction words in the configured lane order;
// lanes left unfilled when the image ends mid-word stay zero.
module byte_packer
    import instr_fetch_pkg::*;
#(
    parameter int INSTR_W    = 32,
    parameter int BIG_ENDIAN = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               accept,
    input  logic [7:0]         data,
    input  logic               last,
    output logic [INSTR_W-1:0] word,
    output logic               word_done
);
    localparam int WORD_BYTES = bytes_per_word(INSTR_W);
    localparam int CNT_BITS   = idx_bits(WORD_BYTES);

    logic [CNT_BITS-1:0] byte_cnt_r;
    logic [INSTR_W-1:0]  partial_r;
    logic [INSTR_W-1:0]  lane_s;
    logic [CNT_BITS+2:0] shift_s;

    assign shift_s   = {byte_cnt_r, 3'b000};
    assign lane_s    = (BIG_ENDIAN != 0) ? ((INSTR_W'(data) << (INSTR_W - 8)) >> shift_s)
                                         : (INSTR_W'(data) << shift_s);
    assign word      = partial_r | lane_s;
    assign word_done = accept && (last || (byte_cnt_r == CNT_BITS'(WORD_BYTES - 1)));

    // Lane counter and partial word; both restart from zero once a word is emitted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt_r <= '0;
            partial_r  <= '0;
        end else if (clear || word_done) begin
            byte_cnt_r <= '0;
            partial_r  <= '0;
        end else if (accept) begin
            byte_cnt_r <= byte_cnt_r + CNT_BITS'(1);
            partial_r  <= word;
        end
    end

endmodule

// File: rtl/instr_fetch_stream.sv
// Instruction fetch unit: a byte-stream loader fills the instruction memory, then
// a PC-driven engine issues instructions downstream over valid/ready.
module instr_fetch_stream
    import instr_fetch_pkg::*;
#(
    parameter int INSTR_W    = 32,
    parameter int DEPTH      = 64,
    parameter int ADDR_W     = 32,
    parameter int PC_INCR    = 4,
    parameter int BIG_ENDIAN = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ld_valid,
    output logic               ld_ready,
    input  logic [7:0]         ld_byte,
    input  logic               ld_last,
    input  logic               reload,
    input  logic               branch,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] instruction,
    output logic [ADDR_W-1:0]  pc_out,
    output logic               loading,
    output logic               fault
);
    localparam int                WIDX_W = idx_bits(DEPTH);
    localparam logic [ADDR_W-1:0] INCR   = ADDR_W'(PC_INCR);
    localparam logic [ADDR_W-1:0] LIMIT  = ADDR_W'(DEPTH * PC_INCR);

    fetch_state_t       state_r;
    logic [ADDR_W-1:0]  pc_r;
    logic [WIDX_W-1:0]  word_idx_r;
    logic               ld_ready_r;
    logic               out_valid_r;
    logic               loading_r;
    logic               fault_r;
    logic [INSTR_W-1:0] instruction_r;
    logic [ADDR_W-1:0]  pc_out_r;
    logic [INSTR_W-1:0] mem_r [DEPTH];

    logic               accept_s;
    logic               clear_s;
    logic               word_done_s;
    logic               issue_s;
    logic               pc_ok_s;
    logic               target_ok_s;
    logic [INSTR_W-1:0] packed_word_s;
    logic [WIDX_W-1:0]  fetch_idx_s;

    // ld_ready_r is only ever high in LOAD, so it alone qualifies a byte accept.
    assign accept_s    = ld_valid && ld_ready_r;
    assign clear_s     = (state_r == ST_FETCH) && reload;
    assign issue_s     = !branch && !reload && (!out_valid_r || out_ready);
    assign pc_ok_s     = ((pc_r % INCR) == '0) && (pc_r < LIMIT);
    assign target_ok_s = (branch_target % INCR) == '0;
    assign fetch_idx_s = WIDX_W'(pc_r / INCR);

    byte_packer #(
        .INSTR_W    (INSTR_W),
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear_s),
        .accept    (accept_s),
        .data      (ld_byte),
        .last      (ld_last),
        .word      (packed_word_s),
        .word_done (word_done_s)
    );

    // Instruction memory write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (word_done_s) begin
            mem_r[word_idx_r] <= packed_word_s;
        end
    end

    // Control FSM with registered handshake outputs and registered memory read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_LOAD;
            pc_r          <= '0;
            word_idx_r    <= '0;
            ld_ready_r    <= 1'b1;
            loading_r     <= 1'b1;
            out_valid_r   <= 1'b0;
            instruction_r <= '0;
            pc_out_r      <= '0;
            fault_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_LOAD: begin
                    if (word_done_s) begin
                        word_idx_r <= word_idx_r + WIDX_W'(1);
                        if (ld_last || (word_idx_r == WIDX_W'(DEPTH - 1))) begin
                            state_r    <= ST_FETCH;
                            ld_ready_r <= 1'b0;
                            loading_r  <= 1'b0;
                            pc_r       <= '0;
                        end
                    end
                end
                ST_FETCH: begin
                    if (reload) begin
                        state_r     <= ST_LOAD;
                        out_valid_r <= 1'b0;
                        word_idx_r  <= '0;
                        ld_ready_r  <= 1'b1;
                        loading_r   <= 1'b1;
                    end else if (branch) begin
                        out_valid_r <= 1'b0;
                        pc_r        <= branch_target;
                        if (!target_ok_s) begin
                            state_r <= ST_FAULT;
                            fault_r <= 1'b1;
                        end
                    end else if (issue_s) begin
                        if (pc_ok_s) begin
                            out_valid_r   <= 1'b1;
                            instruction_r <= mem_r[fetch_idx_s];
                            pc_out_r      <= pc_r;
                            pc_r          <= pc_r + INCR;
                        end else begin
                            state_r     <= ST_FAULT;
                            fault_r     <= 1'b1;
                            out_valid_r <= 1'b0;
                        end
                    end
                end
                ST_FAULT: begin
                    fault_r     <= 1'b1;
                    out_valid_r <= 1'b0;
                    ld_ready_r  <= 1'b0;
                    loading_r   <= 1'b0;
                end
                default: begin
                    state_r     <= ST_FAULT;
                    fault_r     <= 1'b1;
                    out_valid_r <= 1'b0;
                    ld_ready_r  <= 1'b0;
                    loading_r   <= 1'b0;
                end
            endcase
        end
    end

    assign ld_ready    = ld_ready_r;
    assign loading     = loading_r;
    assign out_valid   = out_valid_r;
    assign instruction = instruction_r;
    assign pc_out      = pc_out_r;
    assign fault       = fault_r;

endmodule
